// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver.
// The line is synchronized, a falling edge starts a frame, the start bit is
// re-checked at its midpoint to reject glitches, and every later bit is
// sampled one full bit period after the previous mid-bit sample.
// A stop bit sampled low raises frame_err and parks the receiver until the
// line returns high, so a held-low line is not decoded as a stream of 0x00.
module uart_rx_os #(
  parameter int BIT_CYCLES = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state;
  logic [CW-1:0]        cyc;
  logic [BW-1:0]        bitn;
  logic [DATA_BITS-1:0] sh;

  logic in_meta;
  logic in_s;
  logic in_prev;

  // Two-flop synchronizer plus one history flop for falling-edge detection;
  // reset loads ones so the line looks idle and no false start is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_meta <= 1'b1;
      in_s    <= 1'b1;
      in_prev <= 1'b1;
    end else begin
      in_meta <= in;
      in_s    <= in_meta;
      in_prev <= in_s;
    end
  end

  // Frame decoder: bit timing, start-glitch rejection, shifting and the
  // one-cycle valid/frame_err strobes all come from this single state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cyc       <= '0;
      bitn      <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cyc <= '0;
          if (in_prev && !in_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cyc == HALF_LAST) begin
            cyc   <= '0;
            bitn  <= '0;
            state <= in_s ? ST_IDLE : ST_DATA;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        ST_DATA: begin
          if (cyc == FULL_LAST) begin
            cyc <= '0;
            sh  <= {in_s, sh[DATA_BITS-1:1]};
            if (bitn == BIT_LAST) begin
              state <= ST_STOP;
            end else begin
              bitn <= bitn + BW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        ST_STOP: begin
          if (cyc == FULL_LAST) begin
            cyc <= '0;
            if (in_s) begin
              data  <= sh;
              valid <= 1'b1;
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        ST_BREAK: begin
          cyc <= '0;
          if (in_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: directed scenarios plus randomized traffic.
// The stimulus side plays the transmitter and records, for every frame it
// sends, the event the receiver owes (byte or framing error) and when it is
// due; a negedge monitor checks every output pulse against that record.
module tb_uart_rx_os;

  localparam int BIT  = 16;
  localparam int HALF = BIT / 2;
  localparam int LAT  = (19 * BIT) / 2 + 3;

  typedef struct {
    logic       is_err;
    logic [7:0] b;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle_cnt = 0;
  int         n_valid = 0;
  int         n_err   = 0;
  int         last_valid_cycle = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;

  uart_rx_os #(
    .BIT_CYCLES(BIT),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp frame starts and output pulses.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle_cnt);
    end
  endtask

  // Holds the line at one level for a number of clock cycles; always returns
  // 1 time unit after a rising edge so inputs never change on the edge.
  task automatic applyStimulus(input logic level, input int ncyc);
    in = level;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame at the exact bit rate; a low stop level models a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    exp_t e;
    e.is_err = ~stop_lvl;
    e.b      = b;
    e.due    = cycle_cnt + LAT;
    exp_q.push_back(e);
    applyStimulus(1'b0, BIT);
    for (int i = 0; i < 8; i++) applyStimulus(b[i], BIT);
    applyStimulus(stop_lvl, BIT);
  endtask

  // One frame from a transmitter running 3% slow; bit boundaries rounded to clocks.
  task automatic send_frame_slow(input logic [7:0] b);
    exp_t       e;
    logic [9:0] bits;
    int         prev_bound;
    int         bound_k;
    bits     = {1'b1, b, 1'b0};
    e.is_err = 1'b0;
    e.b      = b;
    e.due    = -1;
    exp_q.push_back(e);
    prev_bound = 0;
    for (int k = 0; k < 10; k++) begin
      bound_k = ((k + 1) * BIT * 103) / 100;
      applyStimulus(bits[k], bound_k - prev_bound);
      prev_bound = bound_k;
    end
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Output monitor: every pulse must match the oldest owed event, pulses are
  // one cycle and exclusive, and data may only move together with valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      model_data = 8'h00;
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (valid && frame_err) checkOutput("pulse_exclusive", 2, 1);
      if ((valid && prev_valid) || (frame_err && prev_err)) checkOutput("pulse_width", 2, 1);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_kind", frame_err, e.is_err);
          if (e.due >= 0) checkOutput("latency", cycle_cnt, e.due);
          if (valid) begin
            checkOutput("valid_data", data, e.b);
            model_data = e.b;
            n_valid++;
            last_valid_cycle = cycle_cnt;
          end else begin
            n_err++;
          end
        end
      end
      if (!valid) checkOutput("data_hold", data, model_data);
      prev_valid = valid;
      prev_err   = frame_err;
    end
  end

  // Global guard so the run always ends even if the DUT misbehaves badly.
  initial begin
    #3000000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  // Main scenario sequence.
  initial begin
    int         start;
    int         nv0;
    int         ne0;
    logic [7:0] b;
    logic       saw_busy;
    logic [7:0] abort_byte;

    rst = 1'b1;
    in  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_valid", valid, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    applyStimulus(1'b1, 2 * BIT);

    // Single byte 0x61 with a pinned absolute latency.
    nv0   = n_valid;
    ne0   = n_err;
    start = cycle_cnt;
    send_frame(8'h61, 1'b1);
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);
    checkOutput("x61_count", n_valid - nv0, 1);
    checkOutput("x61_latency", last_valid_cycle - start, 155);
    checkOutput("x61_data", data, 8'h61);
    checkOutput("x61_no_err", n_err - ne0, 0);
    checkOutput("x61_busy_after", busy, 1'b0);

    // Back-to-back frames with no idle gap.
    nv0 = n_valid;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);
    checkOutput("b2b_count", n_valid - nv0, 3);
    checkOutput("b2b_last_data", data, 8'hA5);

    // Start glitch of 3 clocks: busy must rise and then drop in time.
    nv0 = n_valid;
    ne0 = n_err;
    applyStimulus(1'b0, 3);
    saw_busy = busy;
    for (int i = 0; i < HALF; i++) begin
      if (!busy) break;
      applyStimulus(1'b1, 1);
    end
    checkOutput("glitch_busy_rose", saw_busy, 1'b1);
    checkOutput("glitch_busy_dropped", busy, 1'b0);
    applyStimulus(1'b1, BIT);
    checkOutput("glitch_no_valid", n_valid - nv0, 0);
    checkOutput("glitch_no_err", n_err - ne0, 0);
    send_frame(8'h3C, 1'b1);
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);
    checkOutput("after_glitch_data", data, 8'h3C);

    // Framing error followed by a long break, then a good frame.
    ne0 = n_err;
    nv0 = n_valid;
    send_frame(8'h55, 1'b0);
    checkOutput("ferr_data_kept", data, 8'h3C);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, BIT);
      checkOutput("break_busy", busy, 1'b1);
    end
    applyStimulus(1'b1, BIT);
    checkOutput("break_released", busy, 1'b0);
    send_frame(8'h12, 1'b1);
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);
    checkOutput("ferr_count", n_err - ne0, 1);
    checkOutput("ferr_valid_count", n_valid - nv0, 1);
    checkOutput("after_break_data", data, 8'h12);

    // Reset in the middle of bit 4 of 0x81; the transmitter aborts too.
    nv0 = n_valid;
    ne0 = n_err;
    abort_byte = 8'h81;
    applyStimulus(1'b0, BIT);
    for (int i = 0; i < 4; i++) applyStimulus(abort_byte[i], BIT);
    applyStimulus(abort_byte[4], HALF);
    rst = 1'b1;
    applyStimulus(abort_byte[4], 1);
    rst = 1'b0;
    checkOutput("midreset_data", data, 8'h00);
    checkOutput("midreset_valid", valid, 1'b0);
    checkOutput("midreset_frame_err", frame_err, 1'b0);
    checkOutput("midreset_busy", busy, 1'b0);
    applyStimulus(1'b1, 12 * BIT);
    checkOutput("midreset_no_pulse", (n_valid - nv0) + (n_err - ne0), 0);
    send_frame(8'h7E, 1'b1);
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);
    checkOutput("after_reset_data", data, 8'h7E);

    // Randomized mix of good frames, glitches and framing errors.
    for (int it = 0; it < 30; it++) begin
      int r;
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r == 0) begin
        applyStimulus(1'b0, $urandom_range(1, HALF - 1));
        applyStimulus(1'b1, HALF + 4);
      end else if (r == 1) begin
        send_frame(b, 1'b0);
        applyStimulus(1'b0, $urandom_range(0, 3) * BIT);
        applyStimulus(1'b1, BIT);
      end else begin
        send_frame(b, 1'b1);
        applyStimulus(1'b1, $urandom_range(0, 20));
      end
    end
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);

    // Loopback of all byte values from a 3% slow transmitter, back to back.
    nv0 = n_valid;
    ne0 = n_err;
    for (int v = 0; v < 256; v++) send_frame_slow(8'(v));
    applyStimulus(1'b1, BIT);
    wait_drain(2 * BIT);
    checkOutput("loop_count", n_valid - nv0, 256);
    checkOutput("loop_no_err", n_err - ne0, 0);
    checkOutput("loop_last_data", data, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
